// File: rtl/bridge_pkg.sv
// Shared constants for the bridge_pwm slice: dead-time state encoding,
// default widths and PWM period constants derived from the 12 MHz system clock.
package bridge_pkg;

   localparam int unsigned W_DEF        = 16;
   localparam int unsigned DEADTIME_DEF = 4;
   localparam int unsigned DT_CNT_W     = 8;

   localparam int unsigned CLK_FREQ     = 12_000_000;

   // Centre-aligned: one PWM period is 2P clocks
   function automatic int unsigned period_for(input int unsigned f_hz);
      return CLK_FREQ / (2 * f_hz);
   endfunction

   localparam int unsigned PERIOD_15K   = CLK_FREQ / (2 * 15_000);
   localparam int unsigned PERIOD_20K   = CLK_FREQ / (2 * 20_000);
   localparam int unsigned PERIOD_25K   = CLK_FREQ / (2 * 25_000);

   localparam logic [1:0] DT_OFF = 2'd0;
   localparam logic [1:0] DT_HI  = 2'd1;
   localparam logic [1:0] DT_LO  = 2'd2;

endpackage

// File: rtl/bridge_deadtime.sv
// One bridge leg: registered compare, then complementary gate outputs.
// BRIDGE_PWM_DEADTIME_EN selects the dead-time state machine; otherwise gates are direct complements.
module bridge_deadtime
   import bridge_pkg::*;
#(
   parameter int unsigned W        = W_DEF,
   parameter int unsigned DEADTIME = DEADTIME_DEF
)(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         run_i,
   input  logic [W-1:0] cnt_i,
   input  logic [W-1:0] cmp_i,
   output logic         hi_o,
   output logic         lo_o
);

   if (DEADTIME < 1 || DEADTIME > 255) begin : g_bad_deadtime
      $error("bridge_deadtime: DEADTIME must be within 1..255");
   end

   logic r_raw;
   logic r_hi;
   logic r_lo;

   // Compare keeps tracking while stopped so the first gate after enable is correct
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_raw <= 1'b0;
      end else begin
         r_raw <= (cnt_i < cmp_i);
      end
   end

`ifdef BRIDGE_PWM_DEADTIME_EN
   localparam logic [DT_CNT_W-1:0] DT_LOAD = DT_CNT_W'(DEADTIME - 1);

   logic                r_raw_d;
   logic [1:0]          r_state;
   logic [1:0]          w_state_nxt;
   logic [DT_CNT_W-1:0] r_dt_cnt;
   logic [DT_CNT_W-1:0] w_dt_cnt_nxt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= DT_OFF;
         r_dt_cnt <= DT_LOAD;
         r_raw_d  <= 1'b0;
         r_hi     <= 1'b0;
         r_lo     <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_dt_cnt <= w_dt_cnt_nxt;
         r_raw_d  <= r_raw;
         r_hi     <= (w_state_nxt == DT_HI);
         r_lo     <= (w_state_nxt == DT_LO);
      end
   end

   // Any raw edge (or a stop) drops both gates and restarts the off-time
   always_comb begin
      w_state_nxt  = r_state;
      w_dt_cnt_nxt = r_dt_cnt;
      if (!run_i || (r_raw != r_raw_d)) begin
         w_state_nxt  = DT_OFF;
         w_dt_cnt_nxt = DT_LOAD;
      end else begin
         case (r_state)
            DT_OFF: begin
               if (r_dt_cnt == '0) begin
                  w_state_nxt = r_raw ? DT_HI : DT_LO;
               end else begin
                  w_dt_cnt_nxt = r_dt_cnt - DT_CNT_W'(1);
               end
            end
            DT_HI, DT_LO: w_state_nxt = r_state;
            default: begin
               w_state_nxt  = DT_OFF;
               w_dt_cnt_nxt = DT_LOAD;
            end
         endcase
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_hi <= 1'b0;
         r_lo <= 1'b0;
      end else begin
         r_hi <= run_i & r_raw;
         r_lo <= run_i & ~r_raw;
      end
   end
`endif

   assign hi_o = r_hi;
   assign lo_o = r_lo;

endmodule

// File: rtl/bridge_pwm.sv
// Multi-channel centre-aligned PWM for bridge FET stages: shared triangle counter,
// valley-updated shadow registers, per-channel gate pairs (dead-time via BRIDGE_PWM_DEADTIME_EN).
module bridge_pwm
   import bridge_pkg::*;
#(
   parameter int unsigned N_CH     = 2,
   parameter int unsigned W        = W_DEF,
   parameter int unsigned DEADTIME = DEADTIME_DEF
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable_i,
   input  logic [W-1:0]      period_i,
   input  logic [N_CH*W-1:0] cmp_i,
   output logic [N_CH-1:0]   hi_o,
   output logic [N_CH-1:0]   lo_o,
   output logic              sync_o,
   output logic [W-1:0]      cnt_o
);

   logic [W-1:0]           r_cnt;
   logic                   r_dir_up;
   logic [W-1:0]           r_per_sh;
   logic [N_CH-1:0][W-1:0] r_cmp_sh;
   logic                   r_sync;

   logic [W-1:0]           w_cnt_nxt;
   logic                   w_dir_nxt;
   logic                   w_valley;
   logic                   w_run;
   logic                   w_load;

   assign w_valley = (r_cnt == '0);
   assign w_run    = enable_i && (r_per_sh >= W'(2));
   assign w_load   = w_valley || !enable_i;

   // Turnaround at P keeps P = 2^W-1 legal without wrap
   always_comb begin
      w_cnt_nxt = '0;
      w_dir_nxt = 1'b1;
      if (w_run) begin
         if (w_valley) begin
            w_cnt_nxt = W'(1);
            w_dir_nxt = 1'b1;
         end else if (r_dir_up) begin
            if (r_cnt >= r_per_sh) begin
               w_cnt_nxt = r_cnt - W'(1);
               w_dir_nxt = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt + W'(1);
               w_dir_nxt = 1'b1;
            end
         end else begin
            w_cnt_nxt = r_cnt - W'(1);
            w_dir_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt    <= '0;
         r_dir_up <= 1'b1;
         r_per_sh <= '0;
         r_cmp_sh <= '0;
         r_sync   <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_nxt;
         r_dir_up <= w_dir_nxt;
         r_sync   <= w_run && w_valley;
         if (w_load) begin
            r_per_sh <= period_i;
            r_cmp_sh <= cmp_i;
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      bridge_deadtime #(
         .W        (W),
         .DEADTIME (DEADTIME)
      ) u_deadtime (
         .clk     (clk),
         .reset_n (reset_n),
         .run_i   (w_run),
         .cnt_i   (r_cnt),
         .cmp_i   (r_cmp_sh[g]),
         .hi_o    (hi_o[g]),
         .lo_o    (lo_o[g])
      );
   end

   assign sync_o = r_sync;
   assign cnt_o  = r_cnt;

endmodule

// File: tb/tb_bridge_pwm.sv
// Directed self-checking bench for bridge_pwm (N_CH=2, W=16, DEADTIME=3);
// expectations follow BRIDGE_PWM_DEADTIME_EN when defined.
module tb_bridge_pwm;

`ifdef BRIDGE_PWM_DEADTIME_EN
   localparam int DT = 3;
`else
   localparam int DT = 0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable_i;
   logic [15:0] period_i;
   logic [31:0] cmp_i;
   logic [1:0]  hi_o;
   logic [1:0]  lo_o;
   logic        sync_o;
   logic [15:0] cnt_o;

   int n_cmp = 0;
   int n_err = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   bridge_pwm #(.N_CH(2), .W(16), .DEADTIME(3)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .enable_i (enable_i),
      .period_i (period_i),
      .cmp_i    (cmp_i),
      .hi_o     (hi_o),
      .lo_o     (lo_o),
      .sync_o   (sync_o),
      .cnt_o    (cnt_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int tri_exp(input int j, input int p);
      int m;
      m = j % (2 * p);
      return (m <= p) ? m : (2 * p - m);
   endfunction

   task automatic count_win(input int n, output int h0, output int l0, output int o0,
                            output int h1, output int l1);
      h0 = 0; l0 = 0; o0 = 0; h1 = 0; l1 = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         h0 += int'(hi_o[0]);
         l0 += int'(lo_o[0]);
         o0 += int'(!hi_o[0] && !lo_o[0]);
         h1 += int'(hi_o[1]);
         l1 += int'(lo_o[1]);
      end
   endtask

   task automatic wait_cnt(input string tag, input logic [15:0] v, input bit up_only);
      logic [15:0] prev;
      bit          ok;
      prev = cnt_o;
      ok   = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (cnt_o == v && (!up_only || cnt_o > prev)) begin
            ok = 1'b1;
            break;
         end
         prev = cnt_o;
      end
      chk(tag, 32'(ok), 32'd1);
   endtask

   // Gates of a leg must never be on together
   always @(negedge clk) begin
      if (mon_en) chk("no_overlap", 32'(hi_o & lo_o), 32'd0);
   end

   initial begin
      int h0, l0, o0, h1, l1, mx;
      bit seen;

      reset_n  = 1'b0;
      enable_i = 1'b0;
      period_i = 16'd1;
      cmp_i    = {16'd5, 16'd2};
      repeat (3) @(negedge clk);
      chk("rst_cnt",  32'(cnt_o),  32'd0);
      chk("rst_hi",   32'(hi_o),   32'd0);
      chk("rst_lo",   32'(lo_o),   32'd0);
      chk("rst_sync", 32'(sync_o), 32'd0);
      mon_en  = 1'b1;
      reset_n = 1'b1;

      // Short-period guard: P=1 holds everything at 0
      enable_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("guard_sync", 32'(sync_o), 32'd0);
      end
      chk("guard_cnt", 32'(cnt_o), 32'd0);
      chk("guard_hi",  32'(hi_o),  32'd0);
      chk("guard_lo",  32'(lo_o),  32'd0);

      // Triangle P=4 and sync every 8 cycles
      enable_i = 1'b0;
      period_i = 16'd4;
      @(negedge clk);
      chk("tri_start", 32'(cnt_o), 32'd0);
      enable_i = 1'b1;
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk);
         chk("tri_cnt",  32'(cnt_o),  32'(tri_exp(j, 4)));
         chk("tri_sync", 32'(sync_o), 32'((j % 8) == 1));
      end

      // Duty/dead-time: P=400, ch0 cmp=200, ch1 cmp=401 (always high)
      enable_i = 1'b0;
      period_i = 16'd400;
      cmp_i    = {16'd401, 16'd200};
      repeat (2) @(negedge clk);
      enable_i = 1'b1;
      count_win(1000, h0, l0, o0, h1, l1);
      chk("ext401_lo_warm", 32'(l1), 32'd0);
      count_win(800, h0, l0, o0, h1, l1);
      chk("duty_hi0",   32'(h0), 32'(399 - DT));
      chk("duty_lo0",   32'(l0), 32'(401 - DT));
      chk("duty_off0",  32'(o0), 32'(2 * DT));
      chk("ext401_hi1", 32'(h1), 32'd800);
      chk("ext401_lo1", 32'(l1), 32'd0);

      // Pulse swallowing: cmp=2 gives a 3-cycle raw pulse
      cmp_i = {16'd401, 16'd2};
      count_win(1000, h0, l0, o0, h1, l1);
      count_win(800, h0, l0, o0, h1, l1);
      chk("swallow_hi0", 32'(h0), 32'((DT >= 3) ? 0 : 3));
      chk("swallow_lo0", 32'(l0), 32'(797 - DT));

      // cmp=0: high side never on
      cmp_i = {16'd401, 16'd0};
      count_win(1000, h0, l0, o0, h1, l1);
      count_win(800, h0, l0, o0, h1, l1);
      chk("ext0_hi0", 32'(h0), 32'd0);
      chk("ext0_lo0", 32'(l0), 32'd800);

      // Shadow update mid-cycle: current triangle still peaks at 400
      wait_cnt("wait_150_up", 16'd150, 1'b1);
      period_i = 16'd200;
      mx = 150; seen = 1'b0;
      for (int i = 0; i < 900; i++) begin
         @(negedge clk);
         if (int'(cnt_o) > mx) mx = int'(cnt_o);
         if (cnt_o == 16'd0) begin seen = 1'b1; break; end
      end
      chk("shadow_valley1", 32'(seen), 32'd1);
      chk("shadow_peak400", 32'(mx),   32'd400);
      mx = 0; seen = 1'b0;
      for (int i = 0; i < 900; i++) begin
         @(negedge clk);
         if (int'(cnt_o) > mx) mx = int'(cnt_o);
         if (cnt_o == 16'd0) begin seen = 1'b1; break; end
      end
      chk("shadow_valley2", 32'(seen), 32'd1);
      chk("shadow_peak200", 32'(mx),   32'd200);

      // Stop at cnt=123
      cmp_i = {16'd50, 16'd100};
      wait_cnt("wait_123_stop", 16'd123, 1'b0);
      enable_i = 1'b0;
      @(negedge clk);
      chk("stop_cnt",  32'(cnt_o),  32'd0);
      chk("stop_hi",   32'(hi_o),   32'd0);
      chk("stop_lo",   32'(lo_o),   32'd0);
      chk("stop_sync", 32'(sync_o), 32'd0);

      // Reset at cnt=123
      enable_i = 1'b1;
      wait_cnt("wait_123_rst", 16'd123, 1'b0);
      reset_n = 1'b0;
      @(negedge clk);
      chk("mrst_cnt",  32'(cnt_o),  32'd0);
      chk("mrst_hi",   32'(hi_o),   32'd0);
      chk("mrst_lo",   32'(lo_o),   32'd0);
      chk("mrst_sync", 32'(sync_o), 32'd0);
      reset_n = 1'b1;

      // Random-compare soak; overlap monitor checks every cycle
      for (int k = 0; k < 40; k++) begin
         period_i = 16'($urandom_range(60, 2));
         cmp_i    = {16'($urandom_range(int'(period_i) + 2, 0)),
                     16'($urandom_range(int'(period_i) + 2, 0))};
         enable_i = ($urandom_range(9, 0) != 0);
         repeat (50) @(negedge clk);
      end

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
